// File: rtl/bus_timer_multi_pkg.sv
// Shared constants and types for the multi-channel bus timer:
// register offsets inside a channel's 4-byte window and the CTRL field layout.
package timer_pkg;

  localparam int STRIDE = 4;

  localparam logic [1:0] OFS_PLO  = 2'd0;
  localparam logic [1:0] OFS_PHI  = 2'd1;
  localparam logic [1:0] OFS_CTRL = 2'd2;
  localparam logic [1:0] OFS_STAT = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ONESHOT = 2;

  typedef struct packed {
    logic oneshot;
    logic irq_en;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/bus_timer_multi_if.sv
// Address/control and interrupt handshake of the processor bus.
// The 8-bit data bus itself stays a plain inout on the timer top.
interface bus_timer_multi_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/bus_timer_multi_channel.sv
// One timer channel: period, CTRL, sticky PEND and the tick-driven counter.
// The live count is exported only when TIMER_COUNT_SNAPSHOT_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             we_plo,
  input  logic             we_phi,
  input  logic             we_ctrl,
  input  logic             we_stat,
  input  logic [7:0]       wdata,
`ifdef TIMER_COUNT_SNAPSHOT_EN
  output logic [CNT_W-1:0] count_o,
`endif
  output logic [CNT_W-1:0] period_o,
  output ctrl_t            ctrl_o,
  output logic             pend_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             pend_q, pend_d;
  logic [15:0]      per16;
  logic [CNT_W:0]   cnt_inc;
  logic             expire;

  always_comb begin
    // Byte writes go through a 16-bit view so narrow counters drop the high byte.
    per16 = 16'(period_q);
    if (we_plo) per16[7:0]  = wdata;
    if (we_phi) per16[15:8] = wdata;
    period_d = per16[CNT_W-1:0];

    cnt_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    expire  = tick && ctrl_q.en && (period_q != '0) && (cnt_inc >= {1'b0, period_q});

    count_d = count_q;
    if (we_ctrl && wdata[CTRL_EN] && !ctrl_q.en) count_d = '0;
    else if (expire)                             count_d = '0;
    else if (tick && ctrl_q.en && (period_q != '0)) count_d = cnt_inc[CNT_W-1:0];

    ctrl_d = ctrl_q;
    if (we_ctrl)                      ctrl_d = ctrl_t'(wdata[2:0]);
    else if (expire && ctrl_q.oneshot) ctrl_d.en = 1'b0;

    // A new expiry beats a same-cycle write-1-to-clear.
    pend_d = pend_q;
    if (expire)                  pend_d = 1'b1;
    else if (we_stat && wdata[0]) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      period_q <= '0;
      ctrl_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
    end
  end

`ifdef TIMER_COUNT_SNAPSHOT_EN
  assign count_o  = count_q;
`endif
  assign period_o = period_q;
  assign ctrl_o   = ctrl_q;
  assign pend_o   = pend_q;
  assign expire_o = expire;

endmodule

// File: rtl/bus_timer_multi.sv
// Multi-channel bus timer: shared prescaler, register decode, registered read
// with tri-state drive, interrupt latch. Optional count snapshot: TIMER_COUNT_SNAPSHOT_EN.
module bus_timer_multi
  import timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hD0,
  parameter int         N_CH      = 2,
  parameter int         CNT_W     = 16,
  parameter int         PRESCALE  = 100000
) (
  input  logic             CLK,
  input  logic             RESETN,
  inout  wire  [7:0]       BUS_DATA,
  bus_timer_multi_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [7:0]       rdata_q, rdata_d;
  logic             oe_q, oe_d;
  logic             raise_q, raise_d;

  logic [8:0]       rel9;
  logic             in_rng, wr_en, rd_en, irq_hit;
  logic [5:0]       ch;
  logic [1:0]       ofs;
  logic [15:0]      per16;
  logic [N_CH-1:0]  we_plo, we_phi, we_ctrl, we_stat;
  logic [N_CH-1:0]  exp_v, pend_v;
  logic [CNT_W-1:0] per [N_CH];
  ctrl_t            ctl [N_CH];
`ifdef TIMER_COUNT_SNAPSHOT_EN
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [15:0]      snap16;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (CLK),
      .rst_n    (RESETN),
      .tick     (tick),
      .we_plo   (we_plo[g]),
      .we_phi   (we_phi[g]),
      .we_ctrl  (we_ctrl[g]),
      .we_stat  (we_stat[g]),
      .wdata    (BUS_DATA),
`ifdef TIMER_COUNT_SNAPSHOT_EN
      .count_o  (cnt[g]),
`endif
      .period_o (per[g]),
      .ctrl_o   (ctl[g]),
      .pend_o   (pend_v[g]),
      .expire_o (exp_v[g])
    );
  end

  always_comb begin
    tick  = (pre_q == PW'(PRESCALE - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);

    // Borrow out of the subtraction means the address is below the block.
    rel9   = {1'b0, bus.BUS_ADDR} - {1'b0, BASE_ADDR};
    in_rng = ~rel9[8];
    ch     = rel9[7:2];
    ofs    = rel9[1:0];
    wr_en  = in_rng && bus.BUS_WE;
    rd_en  = in_rng && !bus.BUS_WE;

    we_plo  = '0;
    we_phi  = '0;
    we_ctrl = '0;
    we_stat = '0;
    rdata_d = '0;
    oe_d    = 1'b0;
    per16   = '0;
    irq_hit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (exp_v[c] && ctl[c].irq_en) irq_hit = 1'b1;
      if (ch == 6'(c)) begin
        we_plo[c]  = wr_en && (ofs == OFS_PLO);
        we_phi[c]  = wr_en && (ofs == OFS_PHI);
        we_ctrl[c] = wr_en && (ofs == OFS_CTRL);
        we_stat[c] = wr_en && (ofs == OFS_STAT);
        if (rd_en) begin
          oe_d  = 1'b1;
          per16 = 16'(per[c]);
          case (ofs)
            OFS_PLO:  rdata_d = per16[7:0];
            OFS_PHI:  rdata_d = per16[15:8];
            OFS_CTRL: rdata_d = {5'b0, ctl[c]};
            default:  rdata_d = {7'b0, pend_v[c]};
          endcase
        end
      end
    end

`ifdef TIMER_COUNT_SNAPSHOT_EN
    snap_d = snap_q;
    if (wr_en && (ch == 6'(N_CH)) && (ofs == OFS_PLO)) begin
      for (int c = 0; c < N_CH; c++)
        if (BUS_DATA == 8'(c)) snap_d = cnt[c];
    end
    snap16 = 16'(snap_q);
    if (rd_en && (ch == 6'(N_CH)) && ((ofs == OFS_PLO) || (ofs == OFS_PHI))) begin
      oe_d    = 1'b1;
      rdata_d = (ofs == OFS_PLO) ? snap16[7:0] : snap16[15:8];
    end
`endif

    // A fresh IRQ-enabled expiry wins over an acknowledge in the same cycle.
    raise_d = raise_q;
    if (irq_hit)                    raise_d = 1'b1;
    else if (bus.BUS_INTERRUPT_ACK) raise_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pre_q   <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      raise_q <= 1'b0;
`ifdef TIMER_COUNT_SNAPSHOT_EN
      snap_q  <= '0;
`endif
    end else begin
      pre_q   <= pre_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      raise_q <= raise_d;
`ifdef TIMER_COUNT_SNAPSHOT_EN
      snap_q  <= snap_d;
`endif
    end
  end

  assign BUS_DATA                = oe_q ? rdata_q : 8'hzz;
  assign bus.BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_bus_timer_multi.sv
// Directed bench for bus_timer_multi (PRESCALE=4, N_CH=2, CNT_W=16, BASE 0xD0).
// The data bus is pulled high, so a released bus reads 0xFF.
module tb_bus_timer_multi;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  tri1  [7:0]  BUS_DATA;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  bus_timer_multi_if bif();

  assign BUS_DATA = drv_en ? drv_data : 8'hzz;

  bus_timer_multi #(
    .BASE_ADDR (8'hD0),
    .N_CH      (2),
    .CNT_W     (16),
    .PRESCALE  (4)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .BUS_DATA (BUS_DATA),
    .bus      (bif.slave)
  );

  always #5 CLK = ~CLK;

  // Mirrors the prescaler phase: after each edge, prescaler == cyc % 4.
  always @(posedge CLK) begin
    if (!RESETN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    bif.BUS_ADDR = a; bif.BUS_WE = 1'b1; drv_en = 1'b1; drv_data = v;
    @(negedge CLK);
    bif.BUS_WE = 1'b0; drv_en = 1'b0; bif.BUS_ADDR = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bif.BUS_ADDR = a; bif.BUS_WE = 1'b0;
    @(negedge CLK);
    d = BUS_DATA;
    bif.BUS_ADDR = 8'h00;
  endtask

  task automatic ack_pulse();
    bif.BUS_INTERRUPT_ACK = 1'b1;
    @(negedge CLK);
    bif.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  // Next write lands on a tick edge, so ticks follow at +4, +8, ...
  task automatic align();
    while (cyc % 4 != 3) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_raise got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    checks++;
    if (BUS_DATA !== 8'hFF) begin
      errors++; $display("FAIL reset_bus_released got=%h exp=ff", BUS_DATA);
    end
    RESETN = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      rd(8'hD0 + 8'(i), d);
      checks++;
      if (d !== 8'h00) begin
        errors++; $display("FAIL reset_read addr=%h got=%h exp=00", 8'hD0 + 8'(i), d);
      end
      idle(1);
      checks++;
      if (BUS_DATA !== 8'hFF) begin
        errors++; $display("FAIL read_release addr=%h got=%h exp=ff", 8'hD0 + 8'(i), BUS_DATA);
      end
    end
`ifndef TIMER_COUNT_SNAPSHOT_EN
    rd(8'hD8, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL unmapped_d8 got=%h exp=ff", d);
    end
`endif
  endtask

  task automatic test_periodic();
    logic [7:0] d;
    wr(8'hD0, 8'd3); wr(8'hD1, 8'd0);
    align(); wr(8'hD2, 8'h03);
    idle(11);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL per_early got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    idle(1);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL per_first_raise got=%b exp=1", bif.BUS_INTERRUPT_RAISE);
    end
    rd(8'hD3, d);
    checks++;
    if (d !== 8'h01) begin
      errors++; $display("FAIL per_pend_set got=%h exp=01", d);
    end
    ack_pulse();
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL per_ack_clear got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    rd(8'hD3, d);
    checks++;
    if (d !== 8'h01) begin
      errors++; $display("FAIL per_pend_after_ack got=%h exp=01", d);
    end
    idle(8);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL per_second_early got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    idle(1);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL per_second_raise got=%b exp=1", bif.BUS_INTERRUPT_RAISE);
    end
    wr(8'hD3, 8'h01);
    rd(8'hD3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL per_w1c got=%h exp=00", d);
    end
    ack_pulse();
    wr(8'hD2, 8'h00);
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    logic       seen;
    wr(8'hD4, 8'd2); wr(8'hD5, 8'd0);
    align(); wr(8'hD6, 8'h07);
    idle(7);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL os_early got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    idle(1);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL os_raise got=%b exp=1", bif.BUS_INTERRUPT_RAISE);
    end
    rd(8'hD6, d);
    checks++;
    if (d !== 8'h06) begin
      errors++; $display("FAIL os_ctrl_en_cleared got=%h exp=06", d);
    end
    rd(8'hD7, d);
    checks++;
    if (d !== 8'h01) begin
      errors++; $display("FAIL os_pend got=%h exp=01", d);
    end
    ack_pulse();
    wr(8'hD7, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (bif.BUS_INTERRUPT_RAISE !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL os_no_rearm got=%b exp=0", seen);
    end
    rd(8'hD7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL os_pend_quiet got=%h exp=00", d);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    align(); wr(8'hD2, 8'h03);
    idle(11);
    wr(8'hD3, 8'h01);
    rd(8'hD3, d);
    checks++;
    if (d !== 8'h01) begin
      errors++; $display("FAIL col_set_wins got=%h exp=01", d);
    end
    idle(10);
    ack_pulse();
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL col_ack_vs_expiry got=%b exp=1", bif.BUS_INTERRUPT_RAISE);
    end
    ack_pulse();
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL col_ack_after got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    wr(8'hD3, 8'h01);
    wr(8'hD2, 8'h00);
  endtask

  task automatic test_shrink_zero();
    logic [7:0] d;
    logic       seen;
    wr(8'hD0, 8'd100);
    align(); wr(8'hD2, 8'h03);
    idle(40);
    wr(8'hD0, 8'd5);
    idle(2);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL shrink_early got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    idle(1);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL shrink_expiry got=%b exp=1", bif.BUS_INTERRUPT_RAISE);
    end
    ack_pulse();
    wr(8'hD3, 8'h01);
    idle(16);
    rd(8'hD3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL shrink_count_restart_early got=%h exp=00", d);
    end
    idle(1);
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL shrink_count_restart got=%b exp=1", bif.BUS_INTERRUPT_RAISE);
    end
    ack_pulse();
    wr(8'hD3, 8'h01);
    wr(8'hD0, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      idle(1);
      if (bif.BUS_INTERRUPT_RAISE !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL zero_period_raise got=%b exp=0", seen);
    end
    rd(8'hD3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL zero_period_pend got=%h exp=00", d);
    end
    wr(8'hD2, 8'h00);
  endtask

  task automatic test_snapshot();
    logic [7:0] d;
    wr(8'hD0, 8'h00); wr(8'hD1, 8'h01);
    align(); wr(8'hD2, 8'h01);
    idle(20);
    wr(8'hD8, 8'h00);
`ifdef TIMER_COUNT_SNAPSHOT_EN
    rd(8'hD8, d);
    checks++;
    if (d !== 8'h05) begin
      errors++; $display("FAIL snap_lo got=%h exp=05", d);
    end
    rd(8'hD9, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL snap_hi got=%h exp=00", d);
    end
    wr(8'hD8, 8'h02);
    rd(8'hD8, d);
    checks++;
    if (d !== 8'h05) begin
      errors++; $display("FAIL snap_bad_channel got=%h exp=05", d);
    end
`else
    rd(8'hD8, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL nosnap_d8 got=%h exp=ff", d);
    end
    rd(8'hD9, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL nosnap_d9 got=%h exp=ff", d);
    end
`endif
    checks++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL snap_no_irq got=%b exp=0", bif.BUS_INTERRUPT_RAISE);
    end
    wr(8'hD2, 8'h00);
  endtask

  task automatic test_reset_midcount();
    logic [7:0] d;
    logic       seen;
    wr(8'hD0, 8'd3); wr(8'hD1, 8'd0);
    wr(8'hD2, 8'h03);
    idle(6);
    RESETN = 1'b0;
    idle(2);
    RESETN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (bif.BUS_INTERRUPT_RAISE !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_raise got=%b exp=0", seen);
    end
    rd(8'hD2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL midreset_ctrl got=%h exp=00", d);
    end
  endtask

  initial begin
    bif.BUS_ADDR = 8'h00;
    bif.BUS_WE = 1'b0;
    bif.BUS_INTERRUPT_ACK = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_collision();
    test_shrink_zero();
    test_snapshot();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
